// File: rtl/tour_cmd.sv
// Knight's-tour command sequencer: passes UART commands through when idle and
// replays the stored move list as vertical/horizontal command pairs on start_tour.
module tour_cmd #(
  parameter int LAST_MOVE = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

  typedef struct packed {
    logic       dx_pos;
    logic [2:0] dx_mag;
    logic       dy_pos;
    logic [2:0] dy_mag;
  } leg_t;

  state_t     state_q, state_d;
  logic [4:0] mv_indx_q, mv_indx_d;
  logic       last_move;
  leg_t       leg;
  logic [15:0] vert_cmd, horz_cmd;

  assign mv_indx   = mv_indx_q;
  assign last_move = (mv_indx_q == 5'(LAST_MOVE));

  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    case (state_q)
      IDLE:   if (start_tour) begin
                state_d   = VERT;
                mv_indx_d = 5'd0;
              end
      VERT:   if (clr_cmd_rdy) state_d = WAIT_V;
      WAIT_V: if (send_resp)   state_d = HORZ;
      HORZ:   if (clr_cmd_rdy) state_d = WAIT_H;
      WAIT_H: if (send_resp) begin
                if (last_move) state_d = IDLE;
                else begin
                  state_d   = VERT;
                  mv_indx_d = mv_indx_q + 5'd1;
                end
              end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mv_indx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Lowest set bit wins; an all-zero move falls into the bit-0 arm.
  always_comb begin
    leg = '{dx_pos: 1'b1, dx_mag: 3'd2, dy_pos: 1'b1, dy_mag: 3'd1};
    casez (move)
      8'b0000_0000,
      8'b????_???1: leg = '{1'b1, 3'd1, 1'b1, 3'd2};
      8'b????_??10: leg = '{1'b0, 3'd1, 1'b1, 3'd2};
      8'b????_?100: leg = '{1'b0, 3'd2, 1'b1, 3'd1};
      8'b????_1000: leg = '{1'b0, 3'd2, 1'b0, 3'd1};
      8'b???1_0000: leg = '{1'b0, 3'd1, 1'b0, 3'd2};
      8'b??10_0000: leg = '{1'b1, 3'd1, 1'b0, 3'd2};
      8'b?100_0000: leg = '{1'b1, 3'd2, 1'b0, 3'd1};
      default:      leg = '{1'b1, 3'd2, 1'b1, 3'd1};
    endcase
  end

  assign vert_cmd = {4'b0100, (leg.dy_pos ? 8'h00 : 8'h7F), 1'b0, leg.dy_mag};
  assign horz_cmd = {4'b0101, (leg.dx_pos ? 8'hBF : 8'h3F), 1'b0, leg.dx_mag};

  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = 8'hA5;
    if (state_q != IDLE) begin
      cmd              = (state_q == VERT || state_q == WAIT_V) ? vert_cmd : horz_cmd;
      cmd_rdy          = (state_q == VERT || state_q == HORZ);
      clr_cmd_rdy_UART = 1'b0;
      resp             = (state_q == WAIT_H && last_move) ? 8'hA5 : 8'h5A;
    end
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: passthrough, move decode, full tour, guards, reset.
module tb_tour_cmd;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0]  mem [0:31];
  int          nchk = 0;
  int          nerr = 0;

  // Hand-computed command words indexed by the one-hot bit of the move.
  logic [15:0] vexp [0:7] = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1,
                              16'h47F2, 16'h47F2, 16'h47F1, 16'h4001};
  logic [15:0] hexp [0:7] = '{16'h5BF1, 16'h53F1, 16'h53F2, 16'h53F2,
                              16'h53F1, 16'h5BF1, 16'h5BF2, 16'h5BF2};
  logic [7:0]  dmv  [0:3] = '{8'h08, 8'h0C, 8'h00, 8'h80};
  logic [15:0] dv   [0:3] = '{16'h47F1, 16'h4001, 16'h4002, 16'h4001};
  logic [15:0] dh   [0:3] = '{16'h53F2, 16'h53F2, 16'h5BF1, 16'h5BF2};

  assign move = mem[mv_indx];

  tour_cmd #(.LAST_MOVE(23)) dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clr;
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send;
    send_resp = 1'b1; tick; send_resp = 1'b0;
  endtask

  task automatic pulse_start;
    start_tour = 1'b1; tick; start_tour = 1'b0;
  endtask

  task automatic do_reset;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_tour = 1'b0; clr_cmd_rdy = 1'b1; send_resp = 1'b0;
    cmd_UART = 16'h4BF2; cmd_rdy_UART = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    #3;
    chk("rst_mv_indx", 16'(mv_indx), 16'd0);
    chk("rst_cmd", cmd, 16'h4BF2);
    chk("rst_cmd_rdy", 16'(cmd_rdy), 16'd1);
    chk("rst_resp", 16'(resp), 16'hA5);
    chk("rst_clr_uart", 16'(clr_cmd_rdy_UART), 16'd1);
    clr_cmd_rdy = 1'b0;
    #1;
    chk("rst_clr_uart_lo", 16'(clr_cmd_rdy_UART), 16'd0);
    tick; rst = 1'b0; tick;

    // Passthrough
    chk("pt_cmd", cmd, 16'h4BF2);
    chk("pt_rdy", 16'(cmd_rdy), 16'd1);
    clr_cmd_rdy = 1'b1; #1;
    chk("pt_clr_uart", 16'(clr_cmd_rdy_UART), 16'd1);
    tick; clr_cmd_rdy = 1'b0; #1;
    chk("pt_clr_uart_lo", 16'(clr_cmd_rdy_UART), 16'd0);
    chk("pt_resp", 16'(resp), 16'hA5);

    // Single move with guards
    mem[0] = 8'h01; cmd_rdy_UART = 1'b0;
    pulse_start;
    chk("sm_vcmd", cmd, 16'h4002);
    chk("sm_vrdy", 16'(cmd_rdy), 16'd1);
    chk("sm_vresp", 16'(resp), 16'h5A);
    pulse_send;
    chk("sm_send_in_vert", 16'(cmd_rdy), 16'd1);
    chk("sm_send_in_vert_cmd", cmd, 16'h4002);
    cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; #1;
    chk("sm_clr_uart_blocked", 16'(clr_cmd_rdy_UART), 16'd0);
    chk("sm_no_passthru", cmd, 16'h4002);
    tick; clr_cmd_rdy = 1'b0;
    chk("sm_waitv_rdy", 16'(cmd_rdy), 16'd0);
    pulse_clr;
    chk("sm_clr_in_waitv", 16'(cmd_rdy), 16'd0);
    pulse_send;
    chk("sm_hcmd", cmd, 16'h5BF1);
    chk("sm_hrdy", 16'(cmd_rdy), 16'd1);
    chk("sm_hresp", 16'(resp), 16'h5A);
    pulse_clr;
    chk("sm_waith_rdy", 16'(cmd_rdy), 16'd0);
    chk("sm_waith_resp", 16'(resp), 16'h5A);
    do_reset;
    chk("sm_reset_idle_cmd", cmd, 16'h4BF2);
    tick;

    // Decode table, including non-one-hot and zero moves
    cmd_rdy_UART = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem[0] = dmv[k];
      pulse_start;
      chk($sformatf("dec%0d_v", k), cmd, dv[k]);
      pulse_clr;
      pulse_send;
      chk($sformatf("dec%0d_h", k), cmd, dh[k]);
      do_reset;
      tick;
    end

    // Full 24-move tour
    for (int i = 0; i < 24; i++) mem[i] = 8'h01 << (i % 8);
    cmd_UART = 16'h1234;
    pulse_start;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("t%0d_idx", i), 16'(mv_indx), 16'(i));
      chk($sformatf("t%0d_v", i), cmd, vexp[i % 8]);
      chk($sformatf("t%0d_vrdy", i), 16'(cmd_rdy), 16'd1);
      if (i == 5) begin
        pulse_start;
        chk("guard_start_idx", 16'(mv_indx), 16'd5);
        chk("guard_start_rdy", 16'(cmd_rdy), 16'd1);
      end
      pulse_clr;
      chk($sformatf("t%0d_wv", i), 16'(cmd_rdy), 16'd0);
      pulse_send;
      chk($sformatf("t%0d_h", i), cmd, hexp[i % 8]);
      chk($sformatf("t%0d_hresp", i), 16'(resp), 16'h5A);
      pulse_clr;
      chk($sformatf("t%0d_wh_resp", i), 16'(resp), (i == 23) ? 16'hA5 : 16'h5A);
      pulse_send;
    end
    chk("end_idx", 16'(mv_indx), 16'd23);
    chk("end_cmd", cmd, 16'h1234);
    chk("end_rdy", 16'(cmd_rdy), 16'd0);
    chk("end_resp", 16'(resp), 16'hA5);
    cmd_rdy_UART = 1'b1; #1;
    chk("end_rdy_pt", 16'(cmd_rdy), 16'd1);
    cmd_rdy_UART = 1'b0;
    tick;

    // Reset in WAIT_H at move 10, then restart with simultaneous UART valid
    pulse_start;
    for (int i = 0; i < 10; i++) begin
      pulse_clr; pulse_send; pulse_clr; pulse_send;
    end
    chk("r10_idx", 16'(mv_indx), 16'd10);
    pulse_clr; pulse_send; pulse_clr;
    chk("r10_waith_resp", 16'(resp), 16'h5A);
    #2 rst = 1'b1; #1;
    chk("r10_rst_idx", 16'(mv_indx), 16'd0);
    chk("r10_rst_resp", 16'(resp), 16'hA5);
    chk("r10_rst_cmd", cmd, 16'h1234);
    #1 rst = 1'b0;
    tick;
    cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b1; start_tour = 1'b1; #1;
    chk("sim_pt_cmd", cmd, 16'hBEEF);
    chk("sim_pt_rdy", 16'(cmd_rdy), 16'd1);
    tick; start_tour = 1'b0;
    chk("restart_idx", 16'(mv_indx), 16'd0);
    chk("restart_v", cmd, vexp[0]);
    chk("restart_rdy", 16'(cmd_rdy), 16'd1);
    chk("restart_clr_uart", 16'(clr_cmd_rdy_UART), 16'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/tour_cmd.md
# tour_cmd

Tour command sequencer upstream of the command processor. In normal operation it passes host (UART) commands straight through. On `start_tour` it takes over the command channel. It then replays a stored knight's-tour move list as pairs of vertical and horizontal move commands, paced by the command processor's `clr_cmd_rdy` and `send_resp` handshakes. It also generates the response byte returned to the host.

## Interface
- `LAST_MOVE`, default 23: index of the final tour move; the 5x5 board gives 24 moves, 0..23.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `start_tour`  in  1  one-cycle pulse to begin the tour.
- `move`  in  8  one-hot knight move read combinationally from the move store at `mv_indx`.
- `mv_indx`  out  5  move-store address.
- `cmd_UART`  in  16  command word from the UART wrapper.
- `cmd_rdy_UART`  in  1  UART command valid.
- `clr_cmd_rdy_UART`  out  1  consume strobe back to the UART wrapper.
- `cmd`  out  16  command word to the command processor.
- `cmd_rdy`  out  1  `cmd` valid.
- `clr_cmd_rdy`  in  1  command processor has consumed `cmd`.
- `send_resp`  in  1  command processor has finished the command.
- `resp`  out  8  response byte to the host.

## Operation
- FSM states:
  - IDLE: UART passthrough.
  - VERT: present the vertical leg.
  - WAIT_V: wait for the vertical leg to finish.
  - HORZ: present the horizontal leg.
  - WAIT_H: wait for the horizontal leg to finish.
- Transitions:
  - IDLE -> VERT on `start_tour`; `mv_indx` is cleared to 0 in the same cycle.
  - VERT -> WAIT_V on `clr_cmd_rdy`.
  - WAIT_V -> HORZ on `send_resp`.
  - HORZ -> WAIT_H on `clr_cmd_rdy`.
  - WAIT_H on `send_resp`: go to IDLE if `mv_indx == LAST_MOVE`; otherwise increment `mv_indx` and go to VERT.
- Mux in IDLE: `cmd = cmd_UART`, `cmd_rdy = cmd_rdy_UART`, `clr_cmd_rdy_UART = clr_cmd_rdy`.
- Mux in all other states: `cmd_rdy = (state == VERT | state == HORZ)`, `clr_cmd_rdy_UART = 0`. UART commands are held off until the tour ends.
- Move decode (dx, dy), by bit of `move`:
  - 0: (+1, +2)
  - 1: (-1, +2)
  - 2: (-2, +1)
  - 3: (-2, -1)
  - 4: (-1, -2)
  - 5: (+1, -2)
  - 6: (+2, -1)
  - 7: (+2, +1)
- Non-one-hot `move`: the lowest set bit wins. `move == 0` decodes as bit 0.
- Vertical command: `{4'b0100, hdg, 1'b0, |dy|[2:0]}`. `hdg` = 8'h00 (north) if dy > 0, else 8'h7F (south). No fanfare.
- Horizontal command: `{4'b0101, hdg, 1'b0, |dx|[2:0]}`. `hdg` = 8'hBF (east) if dx > 0, else 8'h3F (west). Fanfare bit `cmd[12] = 1`.
- `cmd` holds in VERT and WAIT_V with the vertical word, and in HORZ and WAIT_H with the horizontal word. `move` must stay stable while `mv_indx` is constant; the move store is read-only during a tour.
- `resp` is combinational:
  - 8'h5A in every tour state, except WAIT_H when `mv_indx == LAST_MOVE`.
  - 8'hA5 in IDLE and in that final WAIT_H.
- Ignored events:
  - `start_tour` outside IDLE.
  - `clr_cmd_rdy` in WAIT_V and WAIT_H.
  - `send_resp` in VERT and HORZ; the command has not been accepted yet.

## Timing
- Reset values: state IDLE, `mv_indx` 0. Outputs then follow IDLE passthrough: `cmd = cmd_UART`, `cmd_rdy = cmd_rdy_UART`, `resp` 8'hA5, `clr_cmd_rdy_UART = clr_cmd_rdy`.
- `start_tour` at edge t puts `cmd_rdy = 1` with the move-0 vertical word in cycle t+1.
- `clr_cmd_rdy` at edge t drops `cmd_rdy` in cycle t+1.
- `send_resp` in WAIT_V at edge t presents the horizontal word with `cmd_rdy = 1` in cycle t+1.
- `send_resp` in WAIT_H, non-final move: `mv_indx` increments at the same edge and the next vertical word appears the following cycle. That word is combinational from the store.
- `send_resp` in WAIT_H, final move: returns to IDLE; `mv_indx` stays at `LAST_MOVE` until the next `start_tour`.
- Reset asserted mid-tour: the block returns to IDLE and `mv_indx` to 0 immediately (asynchronously). No partial command is re-issued after reset.
- `start_tour` and `cmd_rdy_UART` asserted together in IDLE: the tour wins from the next cycle. In that cycle, the UART command is passed through only combinationally.

## Test plan
- Passthrough: in IDLE, drive `cmd_UART` = 16'h4BF2 with `cmd_rdy_UART` = 1, then pulse `clr_cmd_rdy` -> `cmd` = 16'h4BF2, `cmd_rdy` = 1, `clr_cmd_rdy_UART` pulses, `resp` = 8'hA5.
- Single move: `move` = 8'h01, `start_tour` -> `cmd` = 16'h4002. After `clr_cmd_rdy` and then `send_resp`: `cmd` = 16'h5BF1, `cmd_rdy` = 1, `resp` = 8'h5A.
- Move decode: `move` = 8'h08 -> vertical word 16'h47F1, horizontal word 16'h53F2.
- Full tour: handshake every leg for 24 moves -> `mv_indx` steps 0..23. `resp` = 8'hA5 only in the final WAIT_H, then the block returns to IDLE and passthrough resumes.
- Guards:
  - `start_tour` pulsed at move 5 -> `mv_indx` stays 5.
  - `send_resp` pulsed in VERT -> state unchanged and `cmd_rdy` still 1.
  - `cmd_rdy_UART` = 1 mid-tour -> `clr_cmd_rdy_UART` stays 0.
- Reset during WAIT_H at move 10 -> IDLE, `mv_indx` = 0, `resp` = 8'hA5. A new `start_tour` restarts from move 0.
